// File: rtl/gray_pkg.sv
// Shared constants and types for the grey-scale encode/decode paths.
package gray_pkg;

    // BT.601 luma weights scaled by 256; they sum to exactly 256.
    localparam logic [7:0]  LUMA_KR  = 8'd77;
    localparam logic [7:0]  LUMA_KG  = 8'd150;
    localparam logic [7:0]  LUMA_KB  = 8'd29;
    localparam logic [16:0] LUMA_RND = 17'd128;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Per-channel weighted products carried between the two pipeline stages.
    typedef struct packed {
        logic [15:0] pr;
        logic [15:0] pg;
        logic [15:0] pb;
    } prod_t;

endpackage

// File: rtl/luma_mac.sv
// Combinational luma slices: the product slice feeds stage 1, the
// rounded-sum slice feeds stage 2.
module luma_mac
    import gray_pkg::*;
(
    input  rgb_t        rgb_i,
    output prod_t       prod_o,
    input  prod_t       prod_i,
    output logic [7:0]  code_o
);

    logic [16:0] sum_w;

    assign prod_o.pr = 16'(LUMA_KR) * 16'(rgb_i.r);
    assign prod_o.pg = 16'(LUMA_KG) * 16'(rgb_i.g);
    assign prod_o.pb = 16'(LUMA_KB) * 16'(rgb_i.b);

    // Worst case is 65408, so the 17-bit sum never needs saturation.
    assign sum_w  = 17'(prod_i.pr) + 17'(prod_i.pg) + 17'(prod_i.pb) + LUMA_RND;
    assign code_o = 8'(sum_w >> 8);

endmodule

// File: rtl/rgb_gray_encoder.sv
// RGB -> 8-bit luma encoder with frame-buffer write addressing.
// Two registered stages, valid/ready on both sides, 1 pixel/clk.
module rgb_gray_encoder
    import gray_pkg::*;
#(
    parameter int H_PIX  = 640,
    parameter int V_PIX  = 480,
    parameter int ADDR_W = $clog2(H_PIX * V_PIX)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [23:0]       in_rgb,
    input  logic              in_sof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_code,
    output logic [ADDR_W-1:0] out_addr,
    output logic              frame_done,
    output logic              sof_err
);

    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(H_PIX * V_PIX - 1);

    logic              s1_vld_q, s1_vld_d, s1_sof_q;
    prod_t             s1_prod_q;
    logic              s2_vld_q, s2_vld_d, s2_sof_q;
    logic [7:0]        s2_code_q;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              s1_adv, s2_adv, out_xfer, at_last;
    prod_t             prod_w;
    logic [7:0]        code_w;

    luma_mac u_mac (
        .rgb_i  (rgb_t'(in_rgb)),
        .prod_o (prod_w),
        .prod_i (s1_prod_q),
        .code_o (code_w)
    );

    // Stage advance: each stage moves when it is empty or its successor moves.
    always_comb begin
        s2_adv   = !s2_vld_q || out_ready;
        s1_adv   = !s1_vld_q || s2_adv;
        s1_vld_d = s1_adv ? in_valid : s1_vld_q;
        s2_vld_d = s2_adv ? s1_vld_q : s2_vld_q;
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_vld_q;
    assign out_code  = s2_code_q;
    // An sof-tagged pixel always lands at the top of the frame buffer.
    assign out_addr  = s2_sof_q ? '0 : cnt_q;
    assign out_xfer  = s2_vld_q && out_ready;
    assign at_last   = (out_addr == LAST_A);

    assign frame_done = out_xfer && at_last;
    assign sof_err    = out_xfer && s2_sof_q && (cnt_q != '0);

    // Address counter follows the address actually written, wrapping per frame.
    always_comb begin
        cnt_d = cnt_q;
        if (out_xfer) cnt_d = at_last ? '0 : out_addr + 1'b1;
    end

    // Pipeline registers; data only loads when a valid pixel moves in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_sof_q  <= 1'b0;
            s1_prod_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_sof_q  <= 1'b0;
            s2_code_q <= '0;
            cnt_q     <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            cnt_q    <= cnt_d;
            if (in_valid && s1_adv) begin
                s1_prod_q <= prod_w;
                s1_sof_q  <= in_sof;
            end
            if (s1_vld_q && s2_adv) begin
                s2_code_q <= code_w;
                s2_sof_q  <= s1_sof_q;
            end
        end
    end

endmodule

// File: tb/tb_rgb_gray_encoder.sv
// Bench: two encoders (full 640x480 and a tiny 8x4 frame) share one input
// stream; each output side is checked against a scoreboard and address model.
module tb_rgb_gray_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] in_rgb = '0;
    logic        in_sof = 1'b0;
    logic        out_ready = 1'b1;

    logic        a_in_ready, a_out_valid, a_frame_done, a_sof_err;
    logic [7:0]  a_out_code;
    logic [18:0] a_out_addr;
    logic        b_in_ready, b_out_valid, b_frame_done, b_sof_err;
    logic [7:0]  b_out_code;
    logic [4:0]  b_out_addr;

    always #5 clk = ~clk;

    rgb_gray_encoder dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_rgb(in_rgb), .in_sof(in_sof), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_code(a_out_code), .out_addr(a_out_addr), .frame_done(a_frame_done),
        .sof_err(a_sof_err)
    );

    rgb_gray_encoder #(.H_PIX(8), .V_PIX(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_rgb(in_rgb), .in_sof(in_sof), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_code(b_out_code), .out_addr(b_out_addr), .frame_done(b_frame_done),
        .sof_err(b_sof_err)
    );

    typedef struct packed {
        logic        sof;
        logic [7:0]  code;
        logic [31:0] cyc;
    } exp_t;

    typedef struct {
        logic [23:0] rgb;
        logic        sof;
        logic [7:0]  code;
    } vec_t;

    exp_t        qa[$];
    exp_t        qb[$];
    int unsigned cnt_a = 0, cnt_b = 0;
    int          n_cmp = 0, n_err = 0;
    logic [31:0] cyc = 0;
    logic [7:0]  cur_exp = '0;
    logic        bp = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_code = '0;
    logic [18:0] prev_addr = '0;

    function automatic logic [7:0] luma_ref(input logic [23:0] rgb);
        int unsigned r, g, b;
        r = rgb[23:16]; g = rgb[15:8]; b = rgb[7:0];
        return 8'((77 * r + 150 * g + 29 * b + 128) / 256);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard step for one DUT output side.
    task automatic chk_out(input int id, input logic ov, input logic [7:0] oc,
                           input logic [31:0] oa, input logic fd, input logic se,
                           input int unsigned nlast);
        exp_t        e;
        int unsigned c, ea;
        if (ov && out_ready) begin
            if ((id == 0 && qa.size() == 0) || (id == 1 && qb.size() == 0)) begin
                check($sformatf("dut%0d_extra_output", id), 32'd1, 32'd0);
                return;
            end
            if (id == 0) begin e = qa.pop_front(); c = cnt_a; end
            else         begin e = qb.pop_front(); c = cnt_b; end
            ea = e.sof ? 0 : c;
            check($sformatf("dut%0d_code", id), 32'(oc), 32'(e.code));
            check($sformatf("dut%0d_addr", id), oa, ea);
            check($sformatf("dut%0d_frame_done", id), 32'(fd), 32'(ea == nlast));
            check($sformatf("dut%0d_sof_err", id), 32'(se), 32'(e.sof && c != 0));
            if (!bp && id == 0) check("latency", cyc - e.cyc, 32'd2);
            c = (ea == nlast) ? 0 : ea + 1;
            if (id == 0) cnt_a = c; else cnt_b = c;
        end else begin
            check($sformatf("dut%0d_idle_pulses", id), 32'({fd, se}), 32'd0);
        end
    endtask

    // Monitor: sample away from the active edge, retire outputs, then log inputs.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            qa.delete(); qb.delete();
            cnt_a = 0; cnt_b = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(a_out_valid), 32'd1);
                check("hold_data", {5'd0, a_out_addr, a_out_code}, {5'd0, prev_addr, prev_code});
            end
            prev_stall = a_out_valid && !out_ready;
            prev_code  = a_out_code;
            prev_addr  = a_out_addr;
            chk_out(0, a_out_valid, a_out_code, 32'(a_out_addr), a_frame_done, a_sof_err, 640*480-1);
            chk_out(1, b_out_valid, b_out_code, 32'(b_out_addr), b_frame_done, b_sof_err, 31);
            if (in_valid && a_in_ready) qa.push_back('{sof: in_sof, code: cur_exp, cyc: cyc});
            if (in_valid && b_in_ready) qb.push_back('{sof: in_sof, code: cur_exp, cyc: cyc});
        end
    end

    always @(posedge clk) begin
        #1;
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send(input logic [23:0] rgb, input logic sof, input logic [7:0] exp);
        logic acc;
        int   tries;
        in_valid = 1'b1; in_rgb = rgb; in_sof = sof; cur_exp = exp;
        acc = 1'b0; tries = 0;
        while (!acc && tries < 1000) begin
            @(negedge clk);
            acc = a_in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; in_sof = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        tbl[0] = '{24'hFF0000, 1'b1, 8'h4D};
        tbl[1] = '{24'h00FF00, 1'b0, 8'h95};
        tbl[2] = '{24'h0000FF, 1'b0, 8'h1D};
        tbl[3] = '{24'hFFFFFF, 1'b0, 8'hFF};
        tbl[4] = '{24'h000000, 1'b0, 8'h00};
        tbl[5] = '{24'h808080, 1'b0, 8'h80};
        tbl[6] = '{24'h123456, 1'b0, 8'h2E};
        tbl[7] = '{24'h102030, 1'b0, 8'h1D};

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_addr", 32'(a_out_addr), 32'd0);
        check("rst_out_code", 32'(a_out_code), 32'd0);
        check("rst_in_ready", 32'(a_in_ready), 32'd1);
        check("rst_pulses", 32'({a_frame_done, a_sof_err, b_frame_done, b_sof_err}), 32'd0);
        @(posedge clk); #1;

        // Grey sweep, back-to-back
        for (int v = 0; v < 256; v++) send({3{8'(v)}}, v == 0, 8'(v));
        idle(4);

        // Colour table
        do_reset();
        for (int i = 0; i < 8; i++) send(tbl[i].rgb, tbl[i].sof, tbl[i].code);
        idle(4);

        // Random pixels under random backpressure
        bp = 1'b1;
        for (int i = 0; i < 200; i++) begin
            logic [23:0] px;
            px = 24'($urandom);
            send(px, 1'b0, luma_ref(px));
        end
        in_valid = 1'b0;
        bp = 1'b0;
        idle(10);

        // Full small frame, then a new sof right on the wrap
        do_reset();
        for (int i = 0; i < 32; i++) send({3{8'(i * 7)}}, i == 0, 8'(i * 7));
        send(24'hFFFFFF, 1'b1, 8'hFF);
        send(24'h000000, 1'b0, 8'h00);
        idle(4);

        // Short frame: sof after 10 pixels
        do_reset();
        for (int i = 0; i < 10; i++) send(24'h404040, i == 0, 8'h40);
        send(24'hFF0000, 1'b1, 8'h4D);
        send(24'h0000FF, 1'b0, 8'h1D);
        idle(4);

        // Reset with pixels in flight discards them
        for (int i = 0; i < 3; i++) send(24'h202020, 1'b0, 8'h20);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("midreset_out_valid", 32'(a_out_valid), 32'd0);
        check("midreset_out_addr", 32'(a_out_addr), 32'd0);
        @(posedge clk); #1;
        send(24'h00FF00, 1'b0, 8'h95);
        idle(10);

        check("qa_drained", qa.size(), 32'd0);
        check("qb_drained", qb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
